mmio_port_bridge: RTL and testbench

//  Memory-mapped I/O bridge directly downstream of the processor MEM stage (EX/MEM outputs).

---
 rtl/mmio_port_bridge.sv | 142 ++++++++++++++
 tb/tb_mmio_port_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_bridge.sv
// MMIO bridge behind the MEM stage: OUT/IN/EDGE/TIMER registers in a 16-byte window.
// Define MMIO_PORT_BRIDGE_DEBOUNCE_EN to add a per-bit debounce filter on the input path.
module mmio_port_bridge #(
  parameter logic [31:0] IO_BASE         = 32'h1001_0400,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] OUT_RESET       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic        IOSelect,
  output logic [31:0] ReadData,
  output logic [31:0] PortOut,
  output logic        EdgeIrq
);

  typedef enum logic [1:0] {
    RegOut   = 2'd0,
    RegIn    = 2'd1,
    RegEdge  = 2'd2,
    RegTimer = 2'd3
  } regSel_e;

  regSel_e     regSel;
  logic        wrHit;
  logic [7:0]  syncMeta;
  logic [7:0]  syncOut;
  logic [7:0]  inVal;
  logic [7:0]  inPrevQ;
  logic [7:0]  rise;
  logic [7:0]  edgeClr;
  logic [7:0]  edgeQ;
  logic [7:0]  edgeD;
  logic [31:0] outQ;
  logic [31:0] outD;
  logic [31:0] timerQ;
  logic [31:0] timerD;
  logic        irqQ;
  logic        unusedAddr;

  // Byte-lane bits are don't-care: every register is a full word.
  assign unusedAddr = ^Address[1:0];
  assign regSel     = regSel_e'(Address[3:2]);
  assign IOSelect   = (Address[31:4] == IO_BASE[31:4]);
  assign wrHit      = MemWrite & IOSelect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= PortIn;
      syncOut  <= syncMeta;
    end
  end

`ifdef MMIO_PORT_BRIDGE_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cntQ [8];
  logic [CntW-1:0] cntD [8];
  logic [7:0]      inQ;
  logic [7:0]      inD;

  // Counter runs only while the synchronized bit disagrees with IN; any agreement restarts it.
  always_comb begin
    inD = inQ;
    for (int i = 0; i < 8; i++) begin
      cntD[i] = '0;
      if (syncOut[i] != inQ[i]) begin
        if (cntQ[i] == CntLast) begin
          inD[i] = syncOut[i];
        end else begin
          cntD[i] = cntQ[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inQ  <= '0;
      cntQ <= '{default: '0};
    end else begin
      inQ  <= inD;
      cntQ <= cntD;
    end
  end

  assign inVal = inQ;
`else
  localparam int unsigned unusedDebounce = DEBOUNCE_CYCLES;

  assign inVal = syncOut;
`endif

  always_comb begin
    rise    = inVal & ~inPrevQ;
    edgeClr = (wrHit && regSel == RegEdge) ? WriteData[7:0] : 8'h00;
    // Set is ORed in after the clear so a coincident rising edge survives W1C.
    edgeD   = (edgeQ & ~edgeClr) | rise;
    outD    = (wrHit && regSel == RegOut) ? WriteData : outQ;
    timerD  = (wrHit && regSel == RegTimer) ? WriteData : timerQ + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inPrevQ <= '0;
      edgeQ   <= '0;
      outQ    <= OUT_RESET;
      timerQ  <= '0;
      irqQ    <= 1'b0;
    end else begin
      inPrevQ <= inVal;
      edgeQ   <= edgeD;
      outQ    <= outD;
      timerQ  <= timerD;
      irqQ    <= |edgeQ;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && IOSelect) begin
      unique case (regSel)
        RegOut:   ReadData = outQ;
        RegIn:    ReadData = {24'h0, inVal};
        RegEdge:  ReadData = {24'h0, edgeQ};
        RegTimer: ReadData = timerQ;
      endcase
    end
  end

  assign PortOut = outQ;
  assign EdgeIrq = irqQ;

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Bench for mmio_port_bridge: spec-level model checked every cycle plus directed literals.
module tb_mmio_port_bridge;

  localparam logic [31:0] IoBase   = 32'h1001_0400;
  localparam int unsigned DbCycles = 4;
`ifdef MMIO_PORT_BRIDGE_DEBOUNCE_EN
  localparam int unsigned Lat = 2 + DbCycles;
`else
  localparam int unsigned Lat = 2;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic        IOSelect;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
  logic        EdgeIrq;

  int errors = 0;
  int checks = 0;
  bit chkOn  = 1'b0;

  mmio_port_bridge #(
    .IO_BASE        (IoBase),
    .DEBOUNCE_CYCLES(DbCycles),
    .OUT_RESET      (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .PortIn   (PortIn),
    .IOSelect (IOSelect),
    .ReadData (ReadData),
    .PortOut  (PortOut),
    .EdgeIrq  (EdgeIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: register contents as the spec describes them.
  logic [31:0] mOut    = 32'h0;
  logic [31:0] mTimer  = 32'h0;
  logic [7:0]  mIn     = 8'h0;
  logic [7:0]  mInPrev = 8'h0;
  logic [7:0]  mEdge   = 8'h0;
  logic        mIrq    = 1'b0;
  logic [7:0]  pinLast = 8'h0;
  logic [7:0]  syncNow = 8'h0;
  logic [7:0]  syncHist[$];

  function automatic bit isHit(input logic [31:0] a);
    return a[31:4] == IoBase[31:4];
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a, input logic rd);
    if (!(rd && isHit(a))) return 32'h0;
    case (a[3:2])
      2'd0:    return mOut;
      2'd1:    return {24'h0, mIn};
      2'd2:    return {24'h0, mEdge};
      default: return mTimer;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic       wr;
    logic [7:0] clr;
    logic [7:0] risen;
    bit         stable;
    if (!reset) begin
      mOut = 32'h0; mTimer = 32'h0; mIn = 8'h0; mInPrev = 8'h0;
      mEdge = 8'h0; mIrq = 1'b0; pinLast = 8'h0; syncNow = 8'h0;
      syncHist.delete();
    end else begin
      wr    = MemWrite && isHit(Address);
      mIrq  = (mEdge != 8'h0);
      risen = mIn & ~mInPrev;
      clr   = (wr && Address[3:2] == 2'd2) ? WriteData[7:0] : 8'h0;
      mEdge = (mEdge & ~clr) | risen;
      if (wr && Address[3:2] == 2'd0) mOut = WriteData;
      mTimer  = (wr && Address[3:2] == 2'd3) ? WriteData : mTimer + 32'd1;
      mInPrev = mIn;
      syncNow = pinLast;
      pinLast = PortIn;
`ifdef MMIO_PORT_BRIDGE_DEBOUNCE_EN
      syncHist.push_back(syncNow);
      if (syncHist.size() > DbCycles) void'(syncHist.pop_front());
      if (syncHist.size() == DbCycles) begin
        for (int b = 0; b < 8; b++) begin
          stable = 1'b1;
          foreach (syncHist[j]) if (syncHist[j][b] == mIn[b]) stable = 1'b0;
          if (stable) mIn[b] = ~mIn[b];
        end
      end
`else
      mIn = syncNow;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      check("IOSelect", {31'h0, IOSelect}, {31'h0, isHit(Address)});
      check("ReadData", ReadData, modelRead(Address, MemRead));
      check("PortOut", PortOut, mOut);
      check("EdgeIrq", {31'h0, EdgeIrq}, {31'h0, mIrq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    Address = a; MemRead = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    check(name, ReadData, exp);
    check({"model ", name}, modelRead(a, 1'b1), exp);
    tick();
    MemRead = 1'b0;
  endtask

  task automatic chkPort(input logic [31:0] exp, input string name);
    @(negedge clk);
    check(name, PortOut, exp);
    tick();
  endtask

  initial begin
    reset = 1'b0; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h0;
    #1 chkOn = 1'b1;

    // Reset held with activity on every input.
    for (int i = 0; i < 4; i++) begin
      tick();
      Address = IoBase | (32'(i) << 2); WriteData = $urandom;
      MemWrite = (i % 2 == 0); MemRead = 1'b1; PortIn = 8'($urandom);
      @(negedge clk);
      check("rst PortOut", PortOut, 32'h0);
      check("rst ReadData", ReadData, 32'h0);
      check("rst EdgeIrq", {31'h0, EdgeIrq}, 32'h0);
    end
    tick();
    reset = 1'b1; MemWrite = 1'b0; PortIn = 8'h0;
    rd(IoBase + 32'hC, 32'h0, "timer at release");
    rd(IoBase + 32'hC, 32'h1, "timer first edge");

    // OUT register, read-only IN, simultaneous read/write, misses.
    wr(IoBase, 32'hDEAD_BEEF);
    chkPort(32'hDEAD_BEEF, "PortOut store");
    rd(IoBase + 32'h3, 32'hDEAD_BEEF, "OUT unaligned read");
    wr(IoBase + 32'h4, 32'h1234_5678);
    chkPort(32'hDEAD_BEEF, "PortOut after IN store");
    rd(IoBase + 32'h4, 32'h0, "IN after store");
    Address = IoBase; WriteData = 32'h1111_1111; MemWrite = 1'b1; MemRead = 1'b1;
    @(negedge clk);
    check("rw pre-write", ReadData, 32'hDEAD_BEEF);
    tick();
    MemWrite = 1'b0; MemRead = 1'b0;
    chkPort(32'h1111_1111, "rw committed");
    wr(32'h1001_0500, 32'hCAFE_F00D);
    chkPort(32'h1111_1111, "miss write");
    Address = 32'h1001_0500; MemRead = 1'b1;
    @(negedge clk);
    check("miss IOSelect", {31'h0, IOSelect}, 32'h0);
    check("miss ReadData", ReadData, 32'h0);
    tick();
    Address = IoBase; WriteData = 32'h0; MemRead = 1'b0;
    chkPort(32'h1111_1111, "idle hit");

    // Input path, EDGE, EdgeIrq, W1C.
    PortIn = 8'h05;
    repeat (Lat - 1) tick();
    rd(IoBase + 32'h4, 32'h0, "IN before latency");
    rd(IoBase + 32'h4, 32'h5, "IN after latency");
    Address = IoBase + 32'h8; MemRead = 1'b1;
    @(negedge clk);
    check("EDGE set", ReadData, 32'h5);
    check("EdgeIrq lag", {31'h0, EdgeIrq}, 32'h0);
    tick();
    @(negedge clk);
    check("EdgeIrq set", {31'h0, EdgeIrq}, 32'h1);
    tick();
    MemRead = 1'b0;
    wr(IoBase + 32'h8, 32'h1);
    rd(IoBase + 32'h8, 32'h4, "EDGE W1C bit0");

    // Set beats clear on the same bit.
    PortIn = 8'h01;
    repeat (Lat + 2) tick();
    wr(IoBase + 32'h8, 32'h4);
    rd(IoBase + 32'h8, 32'h0, "EDGE cleared");
    PortIn = 8'h05;
    repeat (Lat) tick();
    wr(IoBase + 32'h8, 32'h4);
    rd(IoBase + 32'h8, 32'h4, "EDGE set wins");
    wr(IoBase + 32'h8, 32'hFF);
    rd(IoBase + 32'h8, 32'h0, "EDGE clear all");

    // TIMER load and wrap.
    wr(IoBase + 32'hC, 32'hFFFF_FFFE);
    rd(IoBase + 32'hC, 32'hFFFF_FFFE, "timer loaded");
    rd(IoBase + 32'hC, 32'hFFFF_FFFF, "timer +1");
    rd(IoBase + 32'hC, 32'h0, "timer wrap");

    // Asynchronous reset mid-cycle.
    wr(IoBase, 32'hA5A5_0F0F);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst PortOut", PortOut, 32'h0);
    check("async rst EdgeIrq", {31'h0, EdgeIrq}, 32'h0);
    tick();
    reset = 1'b1;
    rd(IoBase + 32'hC, 32'h0, "timer after async rst");

`ifdef MMIO_PORT_BRIDGE_DEBOUNCE_EN
    PortIn = 8'h00;
    repeat (12) tick();
    wr(IoBase + 32'h8, 32'hFF);
    PortIn = 8'h01;
    repeat (3) tick();
    PortIn = 8'h00;
    repeat (10) tick();
    rd(IoBase + 32'h4, 32'h0, "db glitch IN");
    rd(IoBase + 32'h8, 32'h0, "db glitch EDGE");
    PortIn = 8'h01;
    repeat (5) tick();
    rd(IoBase + 32'h4, 32'h0, "db IN at 5");
    rd(IoBase + 32'h4, 32'h1, "db IN at 6");
    repeat (3) tick();
    PortIn = 8'h00;
    repeat (10) tick();
    rd(IoBase + 32'h8, 32'h1, "db EDGE");
`endif

    tick();
    chkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
